// File: rtl/branch_predict_unit.sv
// Direct-mapped branch predictor: tagged BTB with 2-bit saturating
// direction counters, zero-cycle lookup, ID-stage update and a
// saturating mispredict statistics counter.
module branch_predict_unit #(
    parameter int          PC_W    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int          CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_target,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [1:0]       cnt_q    [ENTRIES];

    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    logic             lk_hit, upd_hit;

    logic             wr_en;
    logic [1:0]       wr_cnt_d;
    logic [PC_W-1:0]  wr_target_d;

    assign if_idx  = if_pc[IDX_W-1:0];
    assign if_tag  = if_pc[PC_W-1:IDX_W];
    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[PC_W-1:IDX_W];

    // Fetch-side lookup from registered table state only, so a same-cycle
    // update is seen by the lookup one cycle later.
    always_comb begin
        lk_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = lk_hit && cnt_q[if_idx][1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc + PC_W'(1);
    end

    // Resolution check and correct-path redirect.
    always_comb begin
        mispredict  = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(1);
    end

    // Next value of the entry addressed by the update: train on hit,
    // allocate as weak-taken on a taken miss, leave alone otherwise.
    always_comb begin
        upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        wr_en       = 1'b0;
        wr_cnt_d    = cnt_q[upd_idx];
        wr_target_d = target_q[upd_idx];
        if (upd_valid) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    wr_target_d = upd_target;
                    if (cnt_q[upd_idx] != 2'b11) begin
                        wr_cnt_d = cnt_q[upd_idx] + 2'b01;
                    end
                end else if (cnt_q[upd_idx] != 2'b00) begin
                    wr_cnt_d = cnt_q[upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                wr_en       = 1'b1;
                wr_cnt_d    = 2'b10;
                wr_target_d = upd_target;
            end
        end
    end

    // Saturating mispredict statistics counter next value.
    always_comb begin
        mis_cnt_d = mis_cnt_q;
        if (mispredict && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
        end
    end

    // Table and statistics registers; reset wins over any pending update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
            mis_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= wr_target_d;
                cnt_q[upd_idx]    <= wr_cnt_d;
            end
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios followed
// by randomized traffic, compared against a behavioural predictor model.
module tb_branch_predict_unit;

    localparam int NE = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        pred_taken0, pred_taken1;
    logic [31:0] pred_target0, pred_target1;
    logic        mispredict0, mispredict1;
    logic [31:0] redirect_pc0, redirect_pc1;
    logic [15:0] mispredict_cnt0;
    logic [1:0]  mispredict_cnt1;

    always #5 clk = ~clk;

    branch_predict_unit dut0 (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken0), .pred_target(pred_target0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict0), .redirect_pc(redirect_pc0),
        .mispredict_cnt(mispredict_cnt0)
    );

    branch_predict_unit #(.CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken1), .pred_target(pred_target1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict1), .redirect_pc(redirect_pc1),
        .mispredict_cnt(mispredict_cnt1)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: one record per slot, strength held as an integer 0..3.
    bit          m_valid  [NE];
    int unsigned m_tag    [NE];
    logic [31:0] m_target [NE];
    int          m_str    [NE];
    int          m_mis16, m_mis2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_str[i] = 1;
        end
        m_mis16 = 0; m_mis2 = 0;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[pc % NE] && (m_tag[pc % NE] == pc / NE);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_str[pc % NE] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
        return m_pred(pc) ? m_target[pc % NE] : pc + 32'd1;
    endfunction

    // One cycle: drive at negedge, check combinational outputs, then clock
    // and check the registered counter against the model.
    task automatic step(input logic [31:0] ipc, input bit v, input logic [31:0] upc,
                        input bit tk, input logic [31:0] tgt,
                        input bit ptk, input logic [31:0] ptgt);
        bit exp_mis;
        int idx;
        if_pc = ipc; upd_valid = v; upd_pc = upc; upd_taken = tk;
        upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
        #1;
        exp_mis = v && ((tk != ptk) || (tk && tgt != ptgt));
        check("pred_taken",  pred_taken0,  m_pred(ipc));
        check("pred_target", pred_target0, m_pred_tgt(ipc));
        check("mispredict",  mispredict0,  exp_mis);
        if (exp_mis) check("redirect_pc", redirect_pc0, tk ? tgt : upc + 32'd1);
        @(posedge clk);
        if (v) begin
            idx = upc % NE;
            if (m_hit(upc)) begin
                if (tk) begin
                    m_target[idx] = tgt;
                    if (m_str[idx] < 3) m_str[idx]++;
                end else if (m_str[idx] > 0) m_str[idx]--;
            end else if (tk) begin
                m_valid[idx] = 1; m_tag[idx] = upc / NE;
                m_target[idx] = tgt; m_str[idx] = 2;
            end
        end
        if (exp_mis) begin
            if (m_mis16 < 65535) m_mis16++;
            if (m_mis2 < 3) m_mis2++;
        end
        #1;
        check("mis_cnt16", mispredict_cnt0, m_mis16);
        check("mis_cnt2",  mispredict_cnt1, m_mis2);
        @(negedge clk);
    endtask

    task automatic lookup(input logic [31:0] ipc);
        step(ipc, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] rpc, rtgt;
        bit rtk;
        rst = 1'b1; if_pc = '0; upd_valid = 0; upd_pc = '0; upd_taken = 0;
        upd_target = '0; upd_pred_taken = 0; upd_pred_target = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Cold lookup
        check("cold_cnt", mispredict_cnt0, 16'd0);
        lookup(32'd14);
        check("cold_pred", pred_taken0, 1'b0);

        // Allocate on taken miss
        step(32'd14, 1, 32'd14, 1, 32'd12, 0, 32'd15);
        lookup(32'd14);
        check("alloc_pred", {pred_taken0, pred_target0}, {1'b1, 32'd12});
        check("alloc_cnt", mispredict_cnt0, 16'd1);

        // Saturate then decay
        repeat (3) step(32'd14, 1, 32'd14, 1, 32'd12, 1, 32'd12);
        step(32'd14, 1, 32'd14, 0, 32'd12, 1, 32'd12);
        step(32'd14, 1, 32'd14, 0, 32'd12, 1, 32'd12);
        lookup(32'd14);
        check("decay_pred", {pred_taken0, pred_target0}, {1'b0, 32'd15});

        // Same-cycle lookup/update: old prediction first, new one next cycle
        step(32'd14, 1, 32'd14, 1, 32'd12, 0, 32'd15);
        lookup(32'd14);
        check("rw_next", {pred_taken0, pred_target0}, {1'b1, 32'd12});

        // Alias conflict at index 14
        step(32'd0, 1, 32'd30, 1, 32'd40, 0, 32'd31);
        lookup(32'd14);
        lookup(32'd30);
        check("alias_30", {pred_taken0, pred_target0}, {1'b1, 32'd40});

        // Asynchronous reset between edges, with an update pending
        if_pc = 32'd30; upd_valid = 1; upd_pc = 32'd7; upd_taken = 1;
        upd_target = 32'd99; upd_pred_taken = 0;
        #2 rst = 1'b1;
        #1;
        check("rst_pred",  pred_taken0, 1'b0);
        check("rst_cnt16", mispredict_cnt0, 16'd0);
        check("rst_cnt2",  mispredict_cnt1, 2'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        lookup(32'd7);
        lookup(32'd30);

        // Statistics saturation: five mispredicts
        for (int i = 0; i < 5; i++) step(32'd100, 1, 32'd100 + i, 1, 32'd200 + i, 0, 32'd0);
        check("sat_cnt2",  mispredict_cnt1, 2'd3);
        check("sat_cnt16", mispredict_cnt0, 16'd5);

        // Randomized traffic over a small PC window to force aliasing
        for (int i = 0; i < 400; i++) begin
            rpc  = $urandom_range(0, 63);
            rtk  = $urandom_range(0, 1);
            rtgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0)
                step($urandom_range(0, 63), $urandom_range(0, 3) != 0, rpc, rtk, rtgt,
                     m_pred(rpc), m_pred_tgt(rpc));
            else
                step($urandom_range(0, 63), 1, rpc, rtk, rtgt,
                     $urandom_range(0, 1), $urandom_range(0, 63));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning PC width in bits; the PC is word-addressed (PC+1 is the next instruction).
REQ-002 SHALL have parameter ENTRIES, default 16, meaning predictor table depth; legal values are powers of 2 from 2 to 256.
REQ-003 SHALL have parameter CNT_W, default 16, meaning mispredict statistics counter width.
REQ-004 SHALL derive local IDX_W = log2(ENTRIES) and TAG_W = PC_W - IDX_W.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port if_pc, input, PC_W, fetch-stage PC to predict.
REQ-008 SHALL have port pred_taken, output, 1, prediction for if_pc.
REQ-009 SHALL have port pred_target, output, PC_W, predicted next PC for if_pc.
REQ-010 SHALL have port upd_valid, input, 1, ID-stage branch/jump resolution strobe.
REQ-011 SHALL have port upd_pc, input, PC_W, PC of the resolved instruction.
REQ-012 SHALL have port upd_taken, input, 1, actual direction (1 for jumps).
REQ-013 SHALL have port upd_target, input, PC_W, actual taken target (PCplusOne + SE_Imm for branches).
REQ-014 SHALL have port upd_pred_taken, input, 1, prediction made at fetch for upd_pc, carried down the pipe.
REQ-015 SHALL have port upd_pred_target, input, PC_W, predicted target carried down the pipe.
REQ-016 SHALL have port mispredict, output, 1, combinational redirect/flush request.
REQ-017 SHALL have port redirect_pc, output, PC_W, correct next PC when mispredict=1.
REQ-018 SHALL have port mispredict_cnt, output, CNT_W, registered saturating count of mispredicts.

Function
REQ-019 SHALL hold per entry: valid (1 bit), tag (TAG_W), target (PC_W), and a 2-bit saturating counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
REQ-020 SHALL compute index = pc[IDX_W-1:0] and tag = pc[PC_W-1:IDX_W].
REQ-021 SHALL assert a lookup hit when the entry at the if_pc index is valid and its tag equals the if_pc tag.
REQ-022 SHALL drive pred_taken = hit AND counter[1], combinationally from registered table state (zero-cycle lookup).
REQ-023 SHALL drive pred_target = stored target when pred_taken=1, otherwise if_pc+1 (mod 2^PC_W).
REQ-024 SHALL assert mispredict = upd_valid AND (upd_taken != upd_pred_taken OR (upd_taken AND upd_target != upd_pred_target)).
REQ-025 SHALL drive redirect_pc = upd_target when upd_taken=1, otherwise upd_pc+1; its value is don't-care when mispredict=0.
REQ-026 SHALL, on an upd_valid edge with an update hit (upd_pc tag matches a valid entry), increment the counter saturating at 11 if taken and decrement it saturating at 00 if not taken; if taken, the entry SHALL also write target = upd_target.
REQ-027 SHALL, on an upd_valid edge with an update miss and upd_taken=1, allocate (overwrite) the entry with valid=1, tag, target=upd_target, and counter=10.
REQ-028 SHALL NOT allocate on an update miss with upd_taken=0; the table is unchanged in that case.
REQ-029 SHALL, when a lookup and an update target the same index in one cycle, return the pre-update (old) entry to the lookup; the new value becomes visible the next cycle.
REQ-030 SHALL increment mispredict_cnt by 1 on each edge where mispredict=1, holding at all-ones once saturated.
REQ-031 SHALL ignore the upd_* inputs, and change no state, while upd_valid=0.

Reset
REQ-032 SHALL, while rst=1 and regardless of clk, clear all valid bits, set all counters to 01, and clear mispredict_cnt to 0.
REQ-033 SHALL reset tags and targets to 0.
REQ-034 SHALL, when rst is asserted mid-operation, discard any update presented in that cycle; the first edge after rst deasserts is the first update accepted.
REQ-035 SHALL, after reset, report pred_taken=0 and pred_target=if_pc+1 for every if_pc.

Verification
REQ-036 SHALL cover cold lookup: after reset, if_pc=14 -> pred_taken=0, pred_target=15.
REQ-037 SHALL cover allocate on a taken miss: upd_pc=14, upd_taken=1, upd_target=12, upd_pred_taken=0 -> mispredict=1 and redirect_pc=12; next cycle if_pc=14 -> pred_taken=1, pred_target=12; mispredict_cnt=1.
REQ-038 SHALL cover counter saturation and decay: three taken hits on PC 14 (counter 11), then two not-taken updates -> counter 01 and pred_taken=0; the first not-taken update, predicted taken, gives mispredict=1 and redirect_pc=15.
REQ-039 SHALL cover an alias conflict (ENTRIES=16): PC 14 is allocated, then upd_pc=30 (same index) taken to 40 -> lookup of PC 14 misses (pred_taken=0) and lookup of PC 30 predicts 40.
REQ-040 SHALL cover same-cycle read/update: lookup and update of PC 14 in the same cycle -> the lookup returns the old prediction, and the next-cycle lookup returns the updated prediction.
REQ-041 SHALL cover reset mid-run: rst is pulsed asynchronously between edges after allocations -> all lookups return not taken and mispredict_cnt=0 immediately; with CNT_W=2 and 5 mispredicts, mispredict_cnt holds at 3.
